hw_accel_gray_engine: RTL and testbench

- User-logic stage directly downstream of the AXI4 slave front end. Consumes its flat register-access strobes (usr_we/usr_waddr/usr_wdata, usr_re/usr_raddr) and returns usr_rdata/usr_rvalid.
- Contains a control/status register bank, an input pixel FIFO, a 2-stage RGB-to-grayscale pipeline and an output FIFO.
- Software pushes RGB words, starts a job of N pixels, then pops grayscale results; a done interrupt is optional.

---
 rtl/hw_accel_gray_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_hw_accel_gray_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hw_accel_gray_engine.sv
// RGB-to-grayscale accelerator behind the flat usr register strobes:
// control/status bank, input pixel FIFO, 2-stage luma pipeline and output FIFO.
module hw_accel_gray_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IN_DEPTH   = 16,
    parameter int OUT_DEPTH  = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_resetn,
    input  logic                  usr_we,
    input  logic [ADDR_WIDTH-1:0] usr_waddr,
    input  logic [DATA_WIDTH-1:0] usr_wdata,
    input  logic                  usr_re,
    input  logic [ADDR_WIDTH-1:0] usr_raddr,
    output logic [DATA_WIDTH-1:0] usr_rdata,
    output logic                  usr_rvalid,
    output logic                  accel_irq
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_COUNT  = 4'h2;
    localparam logic [3:0] OFF_PROC   = 4'h3;
    localparam logic [3:0] OFF_IN     = 4'h4;
    localparam logic [3:0] OFF_OUT    = 4'h5;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t state_reg, state_next;

    logic [3:0] wr_off, rd_off;
    logic       wr_ctrl, wr_status, wr_count, wr_in, rd_out;
    logic       soft_clear, job_start;

    logic       start_reg, irq_en_reg, ovf_reg, udf_reg, done_reg, irq_reg;
    logic [15:0] count_reg, processed_reg, issued_reg;

    logic [23:0]      in_mem [IN_DEPTH];
    logic [IN_AW-1:0] in_wr_ptr_reg, in_rd_ptr_reg;
    logic [IN_AW:0]   in_count_reg;
    logic             in_full, in_empty, in_push, in_pop, ovf_set;
    logic [23:0]      in_head;

    logic [7:0]        out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
    logic [OUT_AW:0]   out_count_reg;
    logic [OUT_AW+1:0] out_occ;
    logic              out_full, out_empty, out_push, out_pop, udf_set;

    logic        s1_valid_reg, s2_valid_reg;
    logic [7:0]  y_reg;
    logic [15:0] sum_w;
    logic [31:0] rd_data_next;
    logic        unused_bits;

    assign wr_off     = usr_waddr[5:2];
    assign rd_off     = usr_raddr[5:2];
    assign wr_ctrl    = usr_we && (wr_off == OFF_CTRL);
    assign wr_status  = usr_we && (wr_off == OFF_STATUS);
    assign wr_count   = usr_we && (wr_off == OFF_COUNT);
    assign wr_in      = usr_we && (wr_off == OFF_IN);
    assign rd_out     = usr_re && (rd_off == OFF_OUT);
    assign soft_clear = wr_ctrl && usr_wdata[1];
    assign job_start  = (state_reg == ST_IDLE) && wr_ctrl && usr_wdata[0] && !usr_wdata[1];

    assign unused_bits = ^{usr_waddr[ADDR_WIDTH-1:6], usr_waddr[1:0],
                           usr_raddr[ADDR_WIDTH-1:6], usr_raddr[1:0],
                           usr_wdata[31:24], sum_w[7:0]};

    // ---------------- input FIFO ----------------
    assign in_full  = (in_count_reg == (IN_AW+1)'(IN_DEPTH));
    assign in_empty = (in_count_reg == '0);
    assign in_push  = wr_in && !in_full;
    assign ovf_set  = wr_in && in_full;
    assign in_head  = in_mem[in_rd_ptr_reg];

    // Issue gate counts pipeline occupancy so the output FIFO can never overflow.
    assign out_occ = {1'b0, out_count_reg}
                   + {{(OUT_AW+1){1'b0}}, s1_valid_reg}
                   + {{(OUT_AW+1){1'b0}}, s2_valid_reg};
    assign in_pop  = (state_reg == ST_RUN) && !in_empty && (issued_reg < count_reg)
                   && (out_occ < (OUT_AW+2)'(OUT_DEPTH)) && !soft_clear;

    always_ff @(posedge axi_aclk) begin
        if (in_push)
            in_mem[in_wr_ptr_reg] <= usr_wdata[23:0];
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            in_wr_ptr_reg <= '0;
            in_rd_ptr_reg <= '0;
            in_count_reg  <= '0;
        end else if (soft_clear) begin
            in_wr_ptr_reg <= '0;
            in_rd_ptr_reg <= '0;
            in_count_reg  <= '0;
        end else begin
            if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + 1'b1;
            if (in_pop)  in_rd_ptr_reg <= in_rd_ptr_reg + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_count_reg <= in_count_reg + 1'b1;
                2'b01:   in_count_reg <= in_count_reg - 1'b1;
                default: in_count_reg <= in_count_reg;
            endcase
        end
    end

    // ---------------- luma pipeline: B*29, G*150, R*77 ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            localparam logic [7:0] COEF = (gi == 0) ? 8'd29 : ((gi == 1) ? 8'd150 : 8'd77);
            logic [15:0] prod_reg;
            always_ff @(posedge axi_aclk or negedge axi_resetn) begin
                if (!axi_resetn)
                    prod_reg <= '0;
                else if (in_pop)
                    prod_reg <= {8'h00, in_head[8*gi +: 8]} * {8'h00, COEF};
            end
        end
    endgenerate

    assign sum_w = g_chan[0].prod_reg + g_chan[1].prod_reg + g_chan[2].prod_reg;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            y_reg        <= '0;
        end else if (soft_clear) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= in_pop;
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg)
                y_reg <= sum_w[15:8];
        end
    end

    // ---------------- output FIFO ----------------
    assign out_full  = (out_count_reg == (OUT_AW+1)'(OUT_DEPTH));
    assign out_empty = (out_count_reg == '0);
    assign out_push  = s2_valid_reg && !out_full && !soft_clear;
    assign out_pop   = rd_out && !out_empty;
    assign udf_set   = rd_out && out_empty;

    always_ff @(posedge axi_aclk) begin
        if (out_push)
            out_mem[out_wr_ptr_reg] <= y_reg;
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
        end else if (soft_clear) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
        end else begin
            if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + 1'b1;
            if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_count_reg <= out_count_reg + 1'b1;
                2'b01:   out_count_reg <= out_count_reg - 1'b1;
                default: out_count_reg <= out_count_reg;
            endcase
        end
    end

    // ---------------- job FSM ----------------
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (job_start)
                    state_next = (count_reg != 16'd0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                if (wr_ctrl && !usr_wdata[0])
                    state_next = ST_IDLE;
                else if (processed_reg == count_reg)
                    state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (soft_clear)
            state_next = ST_IDLE;
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            issued_reg    <= '0;
            processed_reg <= '0;
        end else if (soft_clear || job_start) begin
            issued_reg    <= '0;
            processed_reg <= '0;
        end else begin
            if (in_pop)   issued_reg    <= issued_reg + 1'b1;
            if (out_push) processed_reg <= processed_reg + 1'b1;
        end
    end

    // ---------------- control / status registers ----------------
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            start_reg  <= 1'b0;
            irq_en_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
            done_reg   <= 1'b0;
            count_reg  <= '0;
            irq_reg    <= 1'b0;
        end else begin
            irq_reg <= done_reg & irq_en_reg;
            if (soft_clear) begin
                start_reg <= 1'b0;
                ovf_reg   <= 1'b0;
                udf_reg   <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    start_reg  <= usr_wdata[0];
                    irq_en_reg <= usr_wdata[2];
                end
                if (state_reg == ST_DONE)
                    start_reg <= 1'b0;
                if (wr_count && state_reg != ST_RUN)
                    count_reg <= usr_wdata[15:0];
                // A hardware set in the same cycle as a W1C wins.
                ovf_reg  <= (ovf_reg  & ~(wr_status & usr_wdata[4])) | ovf_set;
                udf_reg  <= (udf_reg  & ~(wr_status & usr_wdata[5])) | udf_set;
                done_reg <= (done_reg & ~(wr_status & usr_wdata[6])) | (state_reg == ST_DONE);
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        rd_data_next = 32'h0;
        case (rd_off)
            OFF_CTRL:   rd_data_next = {29'h0, irq_en_reg, 1'b0, start_reg};
            OFF_STATUS: rd_data_next = {25'h0, done_reg, udf_reg, ovf_reg,
                                        out_empty, out_full, in_empty, in_full};
            OFF_COUNT:  rd_data_next = {16'h0, count_reg};
            OFF_PROC:   rd_data_next = {16'h0, processed_reg};
            OFF_OUT:    rd_data_next = out_empty ? 32'h0 : {24'h0, out_mem[out_rd_ptr_reg]};
            default:    rd_data_next = 32'h0;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            usr_rvalid <= 1'b0;
            usr_rdata  <= '0;
        end else begin
            usr_rvalid <= usr_re;
            usr_rdata  <= usr_re ? rd_data_next : '0;
        end
    end

    assign accel_irq = irq_reg;

endmodule

// File: tb/tb_hw_accel_gray_engine.sv
// Directed + randomized bench for hw_accel_gray_engine; a stream-order queue
// of expected luma values stands in for the FIFOs and pipeline.
module tb_hw_accel_gray_engine;
    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_COUNT  = 32'h08;
    localparam logic [31:0] A_PROC   = 32'h0C;
    localparam logic [31:0] A_IN     = 32'h10;
    localparam logic [31:0] A_OUT    = 32'h14;

    logic        axi_aclk   = 1'b0;
    logic        axi_resetn = 1'b0;
    logic        usr_we     = 1'b0;
    logic        usr_re     = 1'b0;
    logic [31:0] usr_waddr  = '0;
    logic [31:0] usr_wdata  = '0;
    logic [31:0] usr_raddr  = '0;
    logic [31:0] usr_rdata;
    logic        usr_rvalid;
    logic        accel_irq;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    int in_cnt = 0;

    always #5 axi_aclk = ~axi_aclk;

    hw_accel_gray_engine #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .IN_DEPTH(16), .OUT_DEPTH(16)
    ) dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
        .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata),
        .usr_re(usr_re), .usr_raddr(usr_raddr),
        .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .accel_irq(accel_irq)
    );

    function automatic logic [7:0] gray_of(input logic [31:0] w);
        int y;
        y = (77 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0])) / 256;
        return y[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge axi_aclk);
        usr_we = 1'b1; usr_waddr = a; usr_wdata = d;
        @(negedge axi_aclk);
        usr_we = 1'b0;
    endtask

    task automatic raw_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge axi_aclk);
        usr_re = 1'b1; usr_raddr = a;
        @(negedge axi_aclk);
        usr_re = 1'b0;
        d = usr_rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        raw_read(a, d);
        check({tag, "_rvalid"}, {31'h0, usr_rvalid}, 32'h1);
        check(tag, d, exp);
    endtask

    task automatic push_pixel(input logic [31:0] d);
        bus_write(A_IN, d);
        if (in_cnt < 16) begin
            exp_q.push_back(gray_of(d));
            in_cnt++;
        end
    endtask

    task automatic expect_pop(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        read_check(tag, A_OUT, {24'h0, e});
    endtask

    task automatic burst_pop(input int n);
        logic [7:0] e;
        @(negedge axi_aclk);
        usr_re = 1'b1; usr_raddr = A_OUT;
        for (int i = 0; i < n; i++) begin
            @(negedge axi_aclk);
            if (i == n - 1) usr_re = 1'b0;
            e = exp_q.pop_front();
            check("burst_rvalid", {31'h0, usr_rvalid}, 32'h1);
            check("burst_data", usr_rdata, {24'h0, e});
        end
        @(negedge axi_aclk);
        check("burst_rvalid_end", {31'h0, usr_rvalid}, 32'h0);
    endtask

    task automatic wait_done(input string tag, input int max_polls);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < max_polls && !s[6]; i++)
            raw_read(A_STATUS, s);
        check(tag, {31'h0, s[6]}, 32'h1);
    endtask

    initial begin
        int n;
        logic [31:0] lit_px [4];
        logic [31:0] lit_y  [4];
        lit_px = '{32'h00FFFFFF, 32'h00FF0000, 32'h0000FF00, 32'h000000FF};
        lit_y  = '{32'hFF, 32'h4C, 32'h95, 32'h1C};

        repeat (3) @(negedge axi_aclk);
        check("rst_rvalid", {31'h0, usr_rvalid}, 32'h0);
        check("rst_rdata", usr_rdata, 32'h0);
        check("rst_irq", {31'h0, accel_irq}, 32'h0);
        axi_resetn = 1'b1;
        read_check("rst_status", A_STATUS, 32'h0A);
        read_check("rst_proc", A_PROC, 32'h0);
        read_check("rst_ctrl", A_CTRL, 32'h0);

        // Known-colour job with interrupt enabled
        for (int i = 0; i < 4; i++) bus_write(A_IN, lit_px[i]);
        bus_write(A_COUNT, 32'd4);
        bus_write(A_CTRL, 32'h5);
        wait_done("job1_done", 40);
        @(negedge axi_aclk);
        check("job1_irq", {31'h0, accel_irq}, 32'h1);
        read_check("job1_proc", A_PROC, 32'd4);
        read_check("job1_ctrl", A_CTRL, 32'h4);
        for (int i = 0; i < 4; i++) read_check("job1_y", A_OUT, lit_y[i]);
        bus_write(A_STATUS, 32'h40);
        @(negedge axi_aclk);
        check("job1_irq_clr", {31'h0, accel_irq}, 32'h0);
        read_check("job1_status_clr", A_STATUS, 32'h0A);

        // Underflow on empty OUT_DATA
        read_check("udf_data", A_OUT, 32'h0);
        read_check("udf_status", A_STATUS, 32'h2A);
        bus_write(A_STATUS, 32'h20);
        read_check("udf_clr", A_STATUS, 32'h0A);

        // Start with COUNT=0 goes straight to done
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'h1);
        wait_done("cnt0_done", 10);
        read_check("cnt0_ctrl", A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h40);

        // Overflow: 17th push dropped
        for (int i = 0; i < 17; i++) push_pixel($urandom);
        read_check("ovf_status", A_STATUS, 32'h19);
        bus_write(A_COUNT, 32'd16);
        bus_write(A_CTRL, 32'h1);
        wait_done("ovf_done", 60);
        in_cnt -= 16;
        read_check("ovf_status2", A_STATUS, 32'h56);
        for (int i = 0; i < 16; i++) expect_pop("ovf_y");
        bus_write(A_STATUS, 32'h50);
        read_check("ovf_clr", A_STATUS, 32'h0A);

        // Output back-pressure stall at 16, then completion
        for (int i = 0; i < 16; i++) push_pixel($urandom);
        bus_write(A_COUNT, 32'd20);
        bus_write(A_CTRL, 32'h1);
        repeat (30) @(negedge axi_aclk);
        in_cnt -= 16;
        for (int i = 0; i < 4; i++) push_pixel($urandom);
        repeat (10) @(negedge axi_aclk);
        read_check("stall_proc", A_PROC, 32'd16);
        read_check("stall_status", A_STATUS, 32'h04);
        burst_pop(4);
        wait_done("stall_done", 40);
        in_cnt -= 4;
        read_check("stall_proc2", A_PROC, 32'd20);
        for (int i = 0; i < 16; i++) expect_pop("stall_y");
        read_check("stall_status2", A_STATUS, 32'h4A);
        bus_write(A_STATUS, 32'h40);

        // Randomized jobs
        for (int j = 0; j < 3; j++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) push_pixel($urandom);
            bus_write(A_COUNT, n);
            bus_write(A_CTRL, 32'h1);
            wait_done("rnd_done", 40);
            in_cnt -= n;
            read_check("rnd_proc", A_PROC, n);
            for (int i = 0; i < n; i++) expect_pop("rnd_y");
            bus_write(A_STATUS, 32'h40);
        end

        // soft_clear in the middle of a starved job
        bus_write(A_COUNT, 32'd10);
        for (int i = 0; i < 3; i++) push_pixel($urandom);
        bus_write(A_CTRL, 32'h5);
        repeat (10) @(negedge axi_aclk);
        read_check("sc_proc_pre", A_PROC, 32'd3);
        bus_write(A_CTRL, 32'h2);
        exp_q.delete();
        in_cnt = 0;
        read_check("sc_status", A_STATUS, 32'h0A);
        read_check("sc_proc", A_PROC, 32'h0);
        read_check("sc_ctrl", A_CTRL, 32'h4);
        push_pixel($urandom);
        bus_write(A_COUNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        wait_done("sc_restart_done", 20);
        in_cnt -= 1;
        expect_pop("sc_restart_y");
        bus_write(A_STATUS, 32'h40);

        // Reset in the middle of a COUNT=8 job after 3 pixels
        bus_write(A_COUNT, 32'd8);
        for (int i = 0; i < 3; i++) push_pixel($urandom);
        bus_write(A_CTRL, 32'h5);
        repeat (10) @(negedge axi_aclk);
        axi_resetn = 1'b0;
        #1;
        check("mrst_rvalid", {31'h0, usr_rvalid}, 32'h0);
        check("mrst_rdata", usr_rdata, 32'h0);
        check("mrst_irq", {31'h0, accel_irq}, 32'h0);
        exp_q.delete();
        in_cnt = 0;
        repeat (2) @(negedge axi_aclk);
        axi_resetn = 1'b1;
        read_check("mrst_status", A_STATUS, 32'h0A);
        read_check("mrst_proc", A_PROC, 32'h0);
        read_check("mrst_count", A_COUNT, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
